// File: rtl/rv64_pkg.sv
// rv64_pkg: shared RV64 core types and constants.
//   pc_seq_state_t : fetch-PC sequencer FSM encoding (BOOT, RUN, BUBBLE, HALT)
//   INSN_BYTES     : fixed instruction size (no compressed ISA), fetch stride
//   B_TYPE         : instruction format code for conditional branches, shared
//                    with the decoder and the branch unit
package rv64_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } pc_seq_state_t;

    localparam int unsigned INSN_BYTES = 4;
    localparam logic [2:0]  B_TYPE     = 3'b011;

endpackage

// File: rtl/pc_seq_stats.sv
// pc_seq_stats: three saturating event counters for the fetch-PC sequencer.
// Only instantiated when PC_SEQ_STATS_EN is defined.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (clears all counters)
//   br_i           : a live branch is in EX this cycle
//   tk_i           : that branch resolved taken
//   fl_i           : the sequencer issued a flush this cycle
//   branches_o     : count of br_i cycles
//   taken_o        : count of tk_i cycles
//   redirects_o    : count of fl_i cycles
// Every counter sticks at all-ones instead of wrapping.
module pc_seq_stats #(
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              br_i,
    input  logic              tk_i,
    input  logic              fl_i,
    output logic [STAT_W-1:0] branches_o,
    output logic [STAT_W-1:0] taken_o,
    output logic [STAT_W-1:0] redirects_o
);

    logic [STAT_W-1:0] br_q, tk_q, rd_q;
    logic [STAT_W-1:0] br_d, tk_d, rd_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic              en);
        if (en && (v != '1)) begin
            return v + STAT_W'(1);
        end
        return v;
    endfunction

    always_comb begin
        br_d = sat_inc(br_q, br_i);
        tk_d = sat_inc(tk_q, tk_i);
        rd_d = sat_inc(rd_q, fl_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_q <= '0;
            tk_q <= '0;
            rd_q <= '0;
        end else begin
            br_q <= br_d;
            tk_q <= tk_d;
            rd_q <= rd_d;
        end
    end

    assign branches_o  = br_q;
    assign taken_o     = tk_q;
    assign redirects_o = rd_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC sequencer / redirect controller for the RV64 core.
// Static predict-not-taken: fetch runs sequentially until EX resolves a taken
// branch, a jump, a trap or a halt, which then redirects/squashes the front end.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   stall                  : hold the PC, no fetch advance
//   ex_valid               : EX holds a live instruction
//   ex_is_branch/ex_is_jump: EX instruction class
//   branch_taken/_target   : branch unit result and target
//   trap_req/trap_vector   : exception request and handler address
//   halt_req/resume        : enter / leave HALT
//   pc_f, fetch_valid      : fetch PC and whether it is a real fetch
//   flush                  : squash IF/ID and ID/EX (combinational)
//   misalign               : redirect target not 4-byte aligned, turned into a trap
//   state_o                : FSM state for debug
// Optional feature macro PC_SEQ_STATS_EN adds the STAT_W parameter and the
// stat_branches / stat_taken / stat_redirects outputs.
module pc_sequencer
    import rv64_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned BUBBLES  = 2
`ifdef PC_SEQ_STATS_EN
    ,
    parameter int unsigned STAT_W   = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        trap_req,
    input  logic [63:0] trap_vector,
    input  logic        halt_req,
    input  logic        resume,
    output logic [63:0] pc_f,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign,
    output logic [1:0]  state_o
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_redirects
`endif
);

    localparam logic [2:0] BUB_INIT = 3'(BUBBLES);

    pc_seq_state_t state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          redirect;

    assign redirect = (ex_is_branch & branch_taken) | ex_is_jump;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        misalign    = 1'b0;

        unique case (state_q)
            // BOOT does not advance the PC, so the first RUN cycle fetches RESET_PC.
            BOOT: begin
                state_d = RUN;
            end

            // Redirects and traps ignore stall: the target is loaded regardless.
            RUN: begin
                fetch_valid = !stall;
                if (ex_valid && trap_req) begin
                    pc_d    = trap_vector;
                    flush   = 1'b1;
                    state_d = BUBBLE;
                    cnt_d   = BUB_INIT;
                end else if (ex_valid && redirect) begin
                    flush   = 1'b1;
                    state_d = BUBBLE;
                    cnt_d   = BUB_INIT;
                    if (branch_target[1:0] != 2'b00) begin
                        misalign = 1'b1;
                        pc_d     = trap_vector;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (ex_valid && halt_req) begin
                    flush   = 1'b1;
                    state_d = HALT;
                end else if (!stall) begin
                    // Wraps modulo 2^64 by construction.
                    pc_d = pc_q + 64'(INSN_BYTES);
                end
            end

            // EX is squashed during the bubble, so no event is looked at here.
            BUBBLE: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_f    = pc_q;
    assign state_o = state_q;

`ifdef PC_SEQ_STATS_EN
    pc_seq_stats #(
        .STAT_W(STAT_W)
    ) u_stats (
        .clk_i       (clk),
        .rst_i       (rst),
        .br_i        (ex_valid & ex_is_branch),
        .tk_i        (ex_valid & ex_is_branch & branch_taken),
        .fl_i        (flush),
        .branches_o  (stat_branches),
        .taken_o     (stat_taken),
        .redirects_o (stat_redirects)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [63:0] RS = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TV = 64'h0000_0000_8000_1000;
    localparam logic [1:0]  S_BOOT = 2'd0, S_RUN = 2'd1, S_BUB = 2'd2, S_HALT = 2'd3;

    typedef struct {
        logic        r, st, ev, br, jp, tk;
        logic [63:0] tgt;
        logic        trp, hlt, res;
        logic [63:0] epc;
        logic        efv, efl, emis;
        logic [1:0]  est;
        int          id;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        trap_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [63:0] trap_vector = TV;
    logic [63:0] pc_f;
    logic        fetch_valid, flush, misalign;
    logic [1:0]  state_o;
`ifdef PC_SEQ_STATS_EN
    logic [3:0]  stat_branches, stat_taken, stat_redirects;
`endif

    int checks = 0;
    int errors = 0;
    int row_id = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC(RS),
        .BUBBLES (2)
`ifdef PC_SEQ_STATS_EN
        ,
        .STAT_W  (4)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap_req      (trap_req),
        .trap_vector   (trap_vector),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_f          (pc_f),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .misalign      (misalign),
        .state_o       (state_o)
`ifdef PC_SEQ_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken),
        .stat_redirects(stat_redirects)
`endif
    );

    function automatic vec_t mk(logic r, logic st, logic ev, logic br, logic jp, logic tk,
                                logic [63:0] tgt, logic trp, logic hlt, logic res,
                                logic [63:0] epc, logic efv, logic efl, logic emis,
                                logic [1:0] est);
        vec_t v;
        v.r = r; v.st = st; v.ev = ev; v.br = br; v.jp = jp; v.tk = tk;
        v.tgt = tgt; v.trp = trp; v.hlt = hlt; v.res = res;
        v.epc = epc; v.efv = efv; v.efl = efl; v.emis = emis; v.est = est;
        v.id = 0;
        return v;
    endfunction

    function automatic vec_t idle(logic [63:0] epc, logic efv, logic [1:0] est);
        return mk(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, epc, efv, 0, 0, est);
    endfunction

    task automatic chk(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the active edge and queue its expectation.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.r; stall = v.st; ex_valid = v.ev; ex_is_branch = v.br;
        ex_is_jump = v.jp; branch_taken = v.tk; branch_target = v.tgt;
        trap_req = v.trp; halt_req = v.hlt; resume = v.res;
        v.id = row_id;
        row_id++;
        sb.push_back(v);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_f",        e.id, pc_f,                 e.epc);
            chk("fetch_valid", e.id, 64'(fetch_valid),     64'(e.efv));
            chk("flush",       e.id, 64'(flush),           64'(e.efl));
            chk("misalign",    e.id, 64'(misalign),        64'(e.emis));
            chk("state",       e.id, 64'(state_o),         64'(e.est));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset, boot, sequential fetch
        tbl.push_back(mk(1,0,0,0,0,0,64'h0,0,0,0, RS, 0,0,0,S_BOOT));
        tbl.push_back(idle(RS, 0, S_BOOT));
        tbl.push_back(idle(RS, 1, S_RUN));
        tbl.push_back(idle(RS + 4, 1, S_RUN));
        // taken branch without ex_valid is not an event
        tbl.push_back(mk(0,0,0,1,0,1,64'h8000_0700,0,0,0, RS + 8, 1,0,0,S_RUN));
        tbl.push_back(idle(RS + 12, 1, S_RUN));
        // taken BEQ at 8000_0010 -> 8000_0100, two bubbles
        tbl.push_back(mk(0,0,1,1,0,1,64'h8000_0100,0,0,0, 64'h8000_0010, 1,1,0,S_RUN));
        tbl.push_back(idle(64'h8000_0100, 0, S_BUB));
        tbl.push_back(idle(64'h8000_0100, 0, S_BUB));
        tbl.push_back(idle(64'h8000_0100, 1, S_RUN));
        tbl.push_back(idle(64'h8000_0104, 1, S_RUN));
        // not-taken branch: sequential
        tbl.push_back(mk(0,0,1,1,0,0,64'h8000_0900,0,0,0, 64'h8000_0108, 1,0,0,S_RUN));
        // stall with not-taken branch holds pc
        tbl.push_back(mk(0,1,1,1,0,0,64'h8000_0900,0,0,0, 64'h8000_010C, 0,0,0,S_RUN));
        tbl.push_back(mk(0,1,0,0,0,0,64'h0,0,0,0,          64'h8000_010C, 0,0,0,S_RUN));
        // stall with JAL: redirect still taken
        tbl.push_back(mk(0,1,1,0,1,0,64'h8000_0200,0,0,0, 64'h8000_010C, 0,1,0,S_RUN));
        tbl.push_back(idle(64'h8000_0200, 0, S_BUB));
        tbl.push_back(idle(64'h8000_0200, 0, S_BUB));
        tbl.push_back(idle(64'h8000_0200, 1, S_RUN));
        // misaligned target -> misalign pulse, trap vector
        tbl.push_back(mk(0,0,1,1,0,1,64'h8000_0102,0,0,0, 64'h8000_0204, 1,1,1,S_RUN));
        tbl.push_back(idle(TV, 0, S_BUB));
        tbl.push_back(idle(TV, 0, S_BUB));
        tbl.push_back(idle(TV, 1, S_RUN));
        // trap beats taken branch; trap during bubble ignored
        tbl.push_back(mk(0,0,1,1,0,1,64'h8000_0300,1,0,0, TV + 4, 1,1,0,S_RUN));
        tbl.push_back(idle(TV, 0, S_BUB));
        tbl.push_back(mk(0,0,0,0,0,0,64'h0,1,0,0, TV, 0,0,0,S_BUB));
        tbl.push_back(idle(TV, 1, S_RUN));
        // jump beats halt
        tbl.push_back(mk(0,0,1,0,1,0,64'h8000_0600,0,1,0, TV + 4, 1,1,0,S_RUN));
        tbl.push_back(idle(64'h8000_0600, 0, S_BUB));
        tbl.push_back(idle(64'h8000_0600, 0, S_BUB));
        tbl.push_back(idle(64'h8000_0600, 1, S_RUN));
        // halt
        tbl.push_back(mk(0,0,1,0,0,0,64'h0,0,1,0, 64'h8000_0604, 1,1,0,S_RUN));
        tbl.push_back(idle(64'h8000_0604, 0, S_HALT));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // halt held for 10 cycles, then resume without bubble
        for (int i = 0; i < 10; i++) begin
            step(idle(64'h8000_0604, 0, S_HALT));
        end
        step(mk(0,0,0,0,0,0,64'h0,0,0,1, 64'h8000_0604, 0,0,0,S_HALT));
        step(idle(64'h8000_0604, 1, S_RUN));
        step(idle(64'h8000_0608, 1, S_RUN));

        // wrap at 2^64
        step(mk(0,0,1,0,1,0,64'hFFFF_FFFF_FFFF_FFF8,0,0,0, 64'h8000_060C, 1,1,0,S_RUN));
        step(idle(64'hFFFF_FFFF_FFFF_FFF8, 0, S_BUB));
        step(idle(64'hFFFF_FFFF_FFFF_FFF8, 0, S_BUB));
        step(idle(64'hFFFF_FFFF_FFFF_FFF8, 1, S_RUN));
        step(idle(64'hFFFF_FFFF_FFFF_FFFC, 1, S_RUN));
        step(idle(64'h0, 1, S_RUN));
        step(idle(64'h4, 1, S_RUN));

        // reset in the middle of a bubble
        step(mk(0,0,1,0,1,0,64'h8000_0400,0,0,0, 64'h8, 1,1,0,S_RUN));
        step(idle(64'h8000_0400, 0, S_BUB));
        step(mk(1,0,0,0,0,0,64'h0,0,0,0, 64'h8000_0400, 0,0,0,S_BUB));
        step(idle(RS, 0, S_BOOT));
`ifdef PC_SEQ_STATS_EN
        chk("stat_branches_rst",  row_id, 64'(stat_branches),  64'd0);
        chk("stat_taken_rst",     row_id, 64'(stat_taken),     64'd0);
        chk("stat_redirects_rst", row_id, 64'(stat_redirects), 64'd0);
`endif
        step(idle(RS, 1, S_RUN));

`ifdef PC_SEQ_STATS_EN
        // 20 taken branches into 4-bit counters: all saturate at 15
        for (int i = 0; i < 20; i++) begin
            step(mk(0,0,1,1,0,1,64'h8000_0500,0,0,0,
                    (i == 0) ? RS + 4 : 64'h8000_0500, 1,1,0,S_RUN));
            step(idle(64'h8000_0500, 0, S_BUB));
            step(idle(64'h8000_0500, 0, S_BUB));
        end
        step(idle(64'h8000_0500, 1, S_RUN));
        chk("stat_branches",  row_id, 64'(stat_branches),  64'd15);
        chk("stat_taken",     row_id, 64'(stat_taken),     64'd15);
        chk("stat_redirects", row_id, 64'(stat_redirects), 64'd15);
`endif

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
